// File: rtl/grey_1000_rx.sv
// Samples three asynchronous decade Johnson digits and decodes them to binary/BCD 0..999.
// Optional GREY_RX_DELTA_EN: report the modulo-1000 difference between consecutive accepted samples.
module grey_1000_rx #(
    parameter int pGATE    = 1000,
    parameter int pSTABLE  = 2,
    parameter int pTIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [4:0]  i_100,
    input  logic [4:0]  i_010,
    input  logic [4:0]  i_001,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [9:0]  o_bin,
    output logic [11:0] o_bcd,
    output logic        o_err,
    output logic        o_ovr
);

    localparam int CW = (pGATE > 1) ? $clog2(pGATE) : 1;
    localparam int TW = $clog2(pTIMEOUT);

    typedef enum logic [1:0] {IDLE, SAMPLE, CALC, HOLD} state_t;

    state_t         state, state_n;
    logic [14:0]    s1, s2, prev;
    logic [CW-1:0]  cnt;
    logic [2:0]     stab;
    logic [TW-1:0]  tmo;
    logic           tc, same;
    logic           load, set_err, set_ovr, drop_valid;
    logic [4:0]     dh, dt, d_o;
    logic           dec_ok;
    logic [9:0]     cur;
    logic [9:0]     res_bin;
    logic [11:0]    res_bcd;

    // Returns {code_valid, digit}; digit follows the popcount rule even for invalid codes.
    function automatic logic [4:0] jdec(input logic [4:0] c);
        logic [3:0] pop;
        logic       ok;
        pop = 4'(c[0]) + 4'(c[1]) + 4'(c[2]) + 4'(c[3]) + 4'(c[4]);
        case (c)
            5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
            5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000: ok = 1'b1;
            default:                                          ok = 1'b0;
        endcase
        return {ok, (c[4] ? 4'd10 - pop : pop)};
    endfunction

    // NOTE: every clocked register uses non-blocking assignment so all flops sample the same pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
        end else begin
            s1   <= {i_100, i_010, i_001};
            s2   <= s1;
            prev <= s2;
        end
    end

    assign tc   = (cnt == CW'(pGATE - 1));
    assign same = (s2 == prev);

    always_ff @(posedge i_clk) begin
        if (i_rst) cnt <= '0;
        else       cnt <= tc ? '0 : cnt + CW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || state != SAMPLE) begin
            stab <= '0;
            tmo  <= '0;
        end else begin
            stab <= same ? stab + 3'd1 : 3'd0;
            tmo  <= tmo + TW'(1);
        end
    end

    // In CALC, prev holds the sample that satisfied the stability check.
    assign dh     = jdec(prev[14:10]);
    assign dt     = jdec(prev[9:5]);
    assign d_o    = jdec(prev[4:0]);
    assign dec_ok = dh[4] & dt[4] & d_o[4];
    assign cur    = {dh[3:0], 6'b0} + 10'({dh[3:0], 5'b0}) + 10'({dh[3:0], 2'b0})
                  + 10'({dt[3:0], 3'b0}) + 10'({dt[3:0], 1'b0}) + 10'(d_o[3:0]);

`ifdef GREY_RX_DELTA_EN
    logic [9:0]  last;
    logic        primed, prime_load;
    logic [10:0] diff;

    function automatic logic [11:0] bin2bcd(input logic [9:0] b);
        logic [21:0] sr;
        sr = {12'b0, b};
        for (int i = 0; i < 10; i++) begin
            if (sr[13:10] >= 4'd5) sr[13:10] = sr[13:10] + 4'd3;
            if (sr[17:14] >= 4'd5) sr[17:14] = sr[17:14] + 4'd3;
            if (sr[21:18] >= 4'd5) sr[21:18] = sr[21:18] + 4'd3;
            sr = sr << 1;
        end
        return sr[21:10];
    endfunction

    assign diff    = 11'(cur) + 11'd1000 - 11'(last);
    assign res_bin = (diff >= 11'd1000) ? 10'(diff - 11'd1000) : diff[9:0];
    assign res_bcd = bin2bcd(res_bin);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last   <= '0;
            primed <= 1'b0;
        end else if (load || prime_load) begin
            last   <= cur;
            primed <= 1'b1;
        end
    end
`else
    assign res_bin = cur;
    assign res_bcd = {dh[3:0], dt[3:0], d_o[3:0]};
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_n;
    end

    // NOTE: all outputs of this block get defaults first, so no path leaves one unassigned and no latch appears.
    always_comb begin
        state_n    = state;
        load       = 1'b0;
        set_err    = 1'b0;
        set_ovr    = 1'b0;
        drop_valid = 1'b0;
`ifdef GREY_RX_DELTA_EN
        prime_load = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (tc) begin
                    state_n = SAMPLE;
                    set_ovr = o_valid;
                end
            end
            SAMPLE: begin
                if (same && stab == 3'(pSTABLE - 1)) begin
                    state_n = CALC;
                end else if (tmo == TW'(pTIMEOUT - 1)) begin
                    set_err = 1'b1;
                    state_n = IDLE;
                end
            end
            CALC: begin
                if (!dec_ok) begin
                    set_err = 1'b1;
                    state_n = IDLE;
`ifdef GREY_RX_DELTA_EN
                end else if (!primed) begin
                    prime_load = 1'b1;
                    state_n    = IDLE;
`endif
                end else begin
                    load    = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                set_ovr = tc;
                if (o_valid && i_ready) begin
                    drop_valid = 1'b1;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_bin   <= '0;
            o_bcd   <= '0;
            o_err   <= 1'b0;
            o_ovr   <= 1'b0;
        end else begin
            if (set_err) o_err <= 1'b1;
            if (set_ovr) o_ovr <= 1'b1;
            if (load) begin
                o_valid <= 1'b1;
                o_bin   <= res_bin;
                o_bcd   <= res_bcd;
            end else if (drop_valid) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
